// File: rtl/enemy_wave_ctrl.sv
// Enemy wave scheduler: staged release, kill tracking, shared LFSR arbiter.
// Optional difficulty ramp enabled by ENEMY_WAVE_SPEEDUP_EN.
module enemy_wave_ctrl #(
  parameter int          NUM_ENEMIES    = 4,
  parameter int          RELEASE_FRAMES = 30,
  parameter int          CLEAR_FRAMES   = 60,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   game_on,
  input  logic [NUM_ENEMIES-1:0] kill_req,
  input  logic [NUM_ENEMIES-1:0] dir_req,
  output logic [NUM_ENEMIES-1:0] enemy_go,
  output logic [NUM_ENEMIES-1:0] enemy_alive,
  output logic [NUM_ENEMIES-1:0] dir_grant,
  output logic [2:0]             random_num,
  output logic [3:0]             alive_count,
  output logic                   wave_clear,
  output logic [1:0]             speed_level
);

  localparam int N  = NUM_ENEMIES;
  localparam int PW = $clog2(NUM_ENEMIES);
  localparam logic [N-1:0] ONES     = {N{1'b1}};
  localparam logic [3:0]   FULL_CNT = 4'(NUM_ENEMIES);
  localparam logic [2:0]   REL_LAST = 3'(NUM_ENEMIES - 1);
  localparam logic [7:0]   REL_TOP  = 8'(RELEASE_FRAMES - 1);
  localparam logic [7:0]   CLR_TOP  = 8'(CLEAR_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, RELEASE, RUN, CLEAR} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   go_q, go_d;
  logic [N-1:0]   alive_q, alive_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [2:0]     rnd_q, rnd_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           clr_q, clr_d;
  logic [15:0]    lfsr_q, lfsr_d;
  logic [PW-1:0]  rr_q, rr_d;
  logic [7:0]     frame_q, frame_d;
  logic [2:0]     rel_q, rel_d;
  logic [N-1:0]   kvalid, elig;
  logic [3:0]     kcnt;
  logic           rel_tick, rel_done, clr_done, found;

  assign kvalid   = kill_req & go_q & alive_q;
  assign rel_tick = startOfFrame && (frame_q == REL_TOP);
  assign rel_done = rel_tick && (rel_q == REL_LAST);
  assign clr_done = startOfFrame && (frame_q == CLR_TOP);
  assign lfsr_d   = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

  always_comb begin
    kcnt = 4'd0;
    for (int i = 0; i < N; i++) kcnt = kcnt + 4'(kvalid[i]);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!game_on) state_d = IDLE;
    else begin
      unique case (state_q)
        IDLE:    state_d = RELEASE;
        RELEASE: if (rel_done) state_d = RUN;
        RUN:     if (cnt_q == 4'd0) state_d = CLEAR;
        CLEAR:   if (clr_done) state_d = RELEASE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    go_d    = go_q & ~kvalid;
    alive_d = alive_q & ~kvalid;
    cnt_d   = cnt_q - kcnt;
    frame_d = frame_q;
    rel_d   = rel_q;
    clr_d   = 1'b0;
    if (!game_on) begin
      go_d    = '0;
      alive_d = ONES;
      cnt_d   = FULL_CNT;
      frame_d = 8'd0;
      rel_d   = 3'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          go_d    = N'(1);
          alive_d = ONES;
          cnt_d   = FULL_CNT;
          frame_d = 8'd0;
          rel_d   = 3'd1;
        end
        RELEASE: begin
          if (rel_tick) begin
            for (int i = 0; i < N; i++)
              if (rel_q == 3'(i)) go_d[i] = 1'b1;
            rel_d   = rel_q + 3'd1;
            frame_d = 8'd0;
          end else if (startOfFrame && frame_q != 8'hFF) begin
            frame_d = frame_q + 8'd1;
          end
        end
        RUN: begin
          if (cnt_q == 4'd0) begin
            go_d    = '0;
            clr_d   = 1'b1;
            frame_d = 8'd0;
          end
        end
        CLEAR: begin
          if (clr_done) begin
            go_d    = N'(1);
            alive_d = ONES;
            cnt_d   = FULL_CNT;
            frame_d = 8'd0;
            rel_d   = 3'd1;
          end else if (startOfFrame && frame_q != 8'hFF) begin
            frame_d = frame_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Killed requesters and last cycle's winner are masked out immediately
  always_comb begin
    elig  = dir_req & go_q & alive_q & ~kvalid & ~gnt_q;
    gnt_d = '0;
    rr_d  = rr_q;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && elig[(int'(rr_q) + k) % N]) begin
        found = 1'b1;
        gnt_d[(int'(rr_q) + k) % N] = 1'b1;
        rr_d = PW'((int'(rr_q) + k + 1) % N);
      end
    end
    if (!game_on) begin
      gnt_d = '0;
      rr_d  = rr_q;
    end
    rnd_d = (gnt_d != '0) ? lfsr_q[2:0] : 3'd0;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      go_q    <= '0;
      alive_q <= ONES;
      gnt_q   <= '0;
      rnd_q   <= 3'd0;
      cnt_q   <= FULL_CNT;
      clr_q   <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      rr_q    <= '0;
      frame_q <= 8'd0;
      rel_q   <= 3'd0;
    end else begin
      go_q    <= go_d;
      alive_q <= alive_d;
      gnt_q   <= gnt_d;
      rnd_q   <= rnd_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
      lfsr_q  <= lfsr_d;
      rr_q    <= rr_d;
      frame_q <= frame_d;
      rel_q   <= rel_d;
    end
  end

`ifdef ENEMY_WAVE_SPEEDUP_EN
  logic [1:0] spd_q, spd_d;

  always_comb begin
    spd_d = spd_q;
    if (!game_on || state_q == IDLE) spd_d = 2'd0;
    else if (clr_d && spd_q != 2'd3) spd_d = spd_q + 2'd1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) spd_q <= 2'd0;
    else         spd_q <= spd_d;
  end

  assign speed_level = spd_q;
`else
  assign speed_level = 2'd0;
`endif

  assign enemy_go    = go_q;
  assign enemy_alive = alive_q;
  assign dir_grant   = gnt_q;
  assign random_num  = rnd_q;
  assign alive_count = cnt_q;
  assign wave_clear  = clr_q;

endmodule

// File: tb/tb_enemy_wave_ctrl.sv
// Directed bench for enemy_wave_ctrl with 4 enemies and short frame counts.
module tb_enemy_wave_ctrl;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       game_on = 1'b0;
  logic [3:0] kill_req = '0;
  logic [3:0] dir_req = '0;
  logic [3:0] enemy_go, enemy_alive, dir_grant, alive_count;
  logic [2:0] random_num;
  logic       wave_clear;
  logic [1:0] speed_level;

  int total = 0;
  int bad = 0;

  logic [15:0] m_lfsr, m_prev;
  logic [1:0]  exp_spd;

  enemy_wave_ctrl #(
    .NUM_ENEMIES(4), .RELEASE_FRAMES(2),
    .CLEAR_FRAMES(3), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .game_on(game_on), .kill_req(kill_req), .dir_req(dir_req),
    .enemy_go(enemy_go), .enemy_alive(enemy_alive),
    .dir_grant(dir_grant), .random_num(random_num),
    .alive_count(alive_count), .wave_clear(wave_clear),
    .speed_level(speed_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    #12;
    total++;
    if (enemy_go !== 4'b0000 || enemy_alive !== 4'b1111 ||
        dir_grant !== 4'b0000 || random_num !== 3'd0 ||
        alive_count !== 4'd4 || wave_clear !== 1'b0 ||
        speed_level !== 2'd0) begin
      bad++;
      $display("FAIL reset: go=%b alive=%b gnt=%b rnd=%0d cnt=%0d wc=%b spd=%0d",
               enemy_go, enemy_alive, dir_grant, random_num,
               alive_count, wave_clear, speed_level);
    end
    @(negedge clk);
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_release();
    game_on = 1'b1;
    tick();
    total++;
    if (enemy_go !== 4'b0001) begin
      bad++;
      $display("FAIL start_go: got %b want 0001", enemy_go);
    end
    kill_req = 4'b1000;
    tick();
    kill_req = 4'b0000;
    total++;
    if (alive_count !== 4'd4 || enemy_alive !== 4'b1111) begin
      bad++;
      $display("FAIL early_kill: cnt=%0d alive=%b want 4 1111",
               alive_count, enemy_alive);
    end
    frame();
    total++;
    if (enemy_go !== 4'b0001) begin
      bad++;
      $display("FAIL go_f1: got %b want 0001", enemy_go);
    end
    frame();
    total++;
    if (enemy_go !== 4'b0011) begin
      bad++;
      $display("FAIL go_f2: got %b want 0011", enemy_go);
    end
    frame(); frame();
    total++;
    if (enemy_go !== 4'b0111) begin
      bad++;
      $display("FAIL go_f4: got %b want 0111", enemy_go);
    end
    frame(); frame();
    total++;
    if (enemy_go !== 4'b1111 || alive_count !== 4'd4) begin
      bad++;
      $display("FAIL go_f6: go=%b cnt=%0d want 1111 4", enemy_go, alive_count);
    end
  endtask

  task automatic test_arbiter();
    logic [3:0] want [4];
    want[0] = 4'b0001; want[1] = 4'b0010;
    want[2] = 4'b0100; want[3] = 4'b1000;
    dir_req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (dir_grant !== want[i] || random_num !== m_prev[2:0]) begin
        bad++;
        $display("FAIL grant%0d: gnt=%b rnd=%0d want %b %0d",
                 i, dir_grant, random_num, want[i], m_prev[2:0]);
      end
      dir_req = dir_req & ~want[i];
    end
    tick();
    total++;
    if (dir_grant !== 4'b0000 || random_num !== 3'd0) begin
      bad++;
      $display("FAIL grant_idle: gnt=%b rnd=%0d want 0000 0",
               dir_grant, random_num);
    end
  endtask

  task automatic test_kill_clear();
    kill_req = 4'b0101;
    tick();
    kill_req = 4'b0000;
    total++;
    if (enemy_alive !== 4'b1010 || alive_count !== 4'd2 ||
        enemy_go !== 4'b1010) begin
      bad++;
      $display("FAIL kill_0101: alive=%b cnt=%0d go=%b want 1010 2 1010",
               enemy_alive, alive_count, enemy_go);
    end
    kill_req = 4'b1010;
    tick();
    kill_req = 4'b0000;
    total++;
    if (alive_count !== 4'd0 || wave_clear !== 1'b0) begin
      bad++;
      $display("FAIL kill_all: cnt=%0d wc=%b want 0 0", alive_count, wave_clear);
    end
    tick();
    total++;
    if (wave_clear !== 1'b1 || enemy_go !== 4'b0000 ||
        speed_level !== exp_spd) begin
      bad++;
      $display("FAIL wave_clear: wc=%b go=%b spd=%0d want 1 0000 %0d",
               wave_clear, enemy_go, speed_level, exp_spd);
    end
    tick();
    total++;
    if (wave_clear !== 1'b0) begin
      bad++;
      $display("FAIL clear_pulse: wc=%b want 0", wave_clear);
    end
    frame(); frame();
    total++;
    if (enemy_alive !== 4'b0000 || enemy_go !== 4'b0000) begin
      bad++;
      $display("FAIL clear_wait: alive=%b go=%b want 0000 0000",
               enemy_alive, enemy_go);
    end
    frame();
    total++;
    if (enemy_alive !== 4'b1111 || enemy_go !== 4'b0001 ||
        alive_count !== 4'd4 || speed_level !== exp_spd) begin
      bad++;
      $display("FAIL restart: alive=%b go=%b cnt=%0d spd=%0d want 1111 0001 4 %0d",
               enemy_alive, enemy_go, alive_count, speed_level, exp_spd);
    end
  endtask

  task automatic test_abort();
    dir_req = 4'b0001;
    game_on = 1'b0;
    tick();
    total++;
    if (enemy_go !== 4'b0000 || dir_grant !== 4'b0000 ||
        alive_count !== 4'd4 || enemy_alive !== 4'b1111 ||
        random_num !== 3'd0 || speed_level !== 2'd0) begin
      bad++;
      $display("FAIL abort: go=%b gnt=%b cnt=%0d alive=%b rnd=%0d spd=%0d",
               enemy_go, dir_grant, alive_count, enemy_alive,
               random_num, speed_level);
    end
    dir_req = 4'b0000;
  endtask

  task automatic test_release_kill();
    game_on = 1'b1;
    tick();
    kill_req = 4'b0011;
    tick();
    kill_req = 4'b0000;
    total++;
    if (alive_count !== 4'd3 || enemy_alive !== 4'b1110 ||
        enemy_go !== 4'b0000) begin
      bad++;
      $display("FAIL release_kill: cnt=%0d alive=%b go=%b want 3 1110 0000",
               alive_count, enemy_alive, enemy_go);
    end
    frame(); frame();
    total++;
    if (enemy_go !== 4'b0010) begin
      bad++;
      $display("FAIL release_after_kill: go=%b want 0010", enemy_go);
    end
  endtask

  initial begin
`ifdef ENEMY_WAVE_SPEEDUP_EN
    exp_spd = 2'd1;
`else
    exp_spd = 2'd0;
`endif
    test_reset();
    test_release();
    test_arbiter();
    test_kill_clear();
    test_abort();
    test_release_kill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
